hazard_ctrl_sb: RTL

Parametrised pipeline hazard controller for the NSTAGE in-order core. It generates per-register stall and flush vectors from the back-pressure chain, load-use hazards and EXE-stage redirects. It adds a per-architectural-register scoreboard for variable-latency units (mul/div), so ID stalls until the pending write completes. It also adds a registered mode-switch drain sequencer and a stall-cycle performance counter. It sits beside the datapath and drives the enables and clears of the PC and every pipeline register.

---
 rtl/hazard_ctrl_sb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller: back-pressure stall chain, load-use and scoreboard
// interlocks, redirect flushes, mode-switch drain sequencer and stall counter.
module hazard_ctrl_sb #(
  parameter int unsigned NSTAGE    = 5,
  parameter int unsigned RA_W      = 5,
  parameter int unsigned LAT_W     = 3,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RA_W-1:0]          rs1_addr_id,
  input  logic [RA_W-1:0]          rs2_addr_id,
  input  logic                     use_rs1_id,
  input  logic                     use_rs2_id,
  input  logic                     is_load_exe,
  input  logic                     we_reg_exe,
  input  logic [RA_W-1:0]          rd_addr_exe,
  input  logic                     issue_valid_id,
  input  logic [RA_W-1:0]          issue_rd_id,
  input  logic [LAT_W-1:0]         issue_lat_id,
  input  logic                     redirect_exe,
  input  logic                     if_stall,
  input  logic                     mem_stall,
  input  logic                     switch_mode,
  output logic [NSTAGE-1:0]        stall_o,
  output logic [NSTAGE-1:0]        flush_o,
  output logic [(2**RA_W)-1:0]     sb_busy_o,
  output logic [31:0]              perf_stall_cnt_o
);

  localparam int unsigned NREG = 2 ** RA_W;
  localparam int unsigned DC_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  logic [LAT_W-1:0]  cnt [NREG];
  logic [DC_W-1:0]   drain_cnt;
  logic              sw_q;

  logic              rise_c;
  logic              drain_active_c;
  logic              load_use_c;
  logic              raw_c;
  logic              waw_c;
  logic              hz_id_c;
  logic              issue_fire_c;
  logic [LAT_W-1:0]  lat_eff_c;
  logic [NSTAGE-1:0] stall_c;
  logic [NSTAGE-1:0] flush_c;

  assign rise_c         = switch_mode & ~sw_q;
  assign drain_active_c = (drain_cnt != '0) | rise_c;

  // ID-stage interlocks: load-use against EXE, RAW/WAW against pending long-latency writes
  always_comb begin
    load_use_c = is_load_exe & we_reg_exe & (rd_addr_exe != '0) &
                 ((use_rs1_id & (rs1_addr_id == rd_addr_exe)) |
                  (use_rs2_id & (rs2_addr_id == rd_addr_exe)));
    raw_c      = (use_rs1_id & (rs1_addr_id != '0) & (cnt[rs1_addr_id] != '0)) |
                 (use_rs2_id & (rs2_addr_id != '0) & (cnt[rs2_addr_id] != '0));
    waw_c      = issue_valid_id & (issue_rd_id != '0) & (cnt[issue_rd_id] != '0);
    hz_id_c    = load_use_c | raw_c | waw_c;
  end

  // Stall propagates upstream from the back end; flushes bubble the first free register
  always_comb begin
    stall_c = '0;
    flush_c = '0;
    stall_c[NSTAGE-1] = mem_stall;
    for (int k = int'(NSTAGE) - 2; k >= 2; k--) begin
      stall_c[k] = stall_c[k+1];
    end
    stall_c[1] = hz_id_c | stall_c[2];
    stall_c[0] = stall_c[1] | if_stall | drain_active_c;
    for (int k = 1; k < int'(NSTAGE); k++) begin
      flush_c[k] = stall_c[k-1] & ~stall_c[k];
    end
    // A redirect blocked by back-pressure stays asserted in EXE and lands on release
    if (redirect_exe && !stall_c[2]) begin
      flush_c[1] = 1'b1;
      flush_c[2] = 1'b1;
    end
    if (drain_active_c) begin
      flush_c[NSTAGE-1:1] = '1;
    end
  end

  assign stall_o = rst ? '0 : stall_c;
  assign flush_o = rst ? '0 : flush_c;

  assign lat_eff_c    = (issue_lat_id == '0) ? LAT_W'(1) : issue_lat_id;
  assign issue_fire_c = issue_valid_id & ~stall_c[1] & ~flush_c[2] &
                        ~drain_active_c & (issue_rd_id != '0);

  always_comb begin
    sb_busy_o = '0;
    for (int r = 1; r < int'(NREG); r++) begin
      sb_busy_o[r] = (cnt[r] != '0);
    end
  end

  // Scoreboard counters run independently of pipeline stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NREG); r++) begin
        if (rise_c) begin
          cnt[r] <= '0;
        end else if (issue_fire_c && (issue_rd_id == RA_W'(r))) begin
          cnt[r] <= lat_eff_c;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

  // Drain sequencer: edge cycle plus DRAIN_CYC following cycles, retriggerable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_q      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      sw_q <= switch_mode;
      if (rise_c) begin
        drain_cnt <= DC_W'(DRAIN_CYC);
      end else if (drain_cnt != '0) begin
        drain_cnt <= drain_cnt - DC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt_o <= '0;
    end else if (stall_c[0]) begin
      perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end

endmodule
